disp_row_scheduler: RTL
=======================

Name: disp_row_scheduler

Overview:
- Sequences one compute_max_disp engine across every valid window position of a WIN-row band.
- Accepts a band handshake from the line buffer, then for each column: resets the engine, pulses start with col_index, and waits for done (bounded by a timeout).
- Emits one disparity per column on a valid/ready stream to the depth-map writer.
- Sits between the line buffer and the engine. Carries no pixel data itself.

Parameters:
- WIN, 15, window side; columns scanned 0..IMG_W-WIN
- IMG_W, 64, image width in pixels
- MAX_DISP, 64, disparity range; DISP_BITS = $clog2(MAX_DISP)
- TIMEOUT, 4096, max cycles to wait for eng_done per column; TMR_BITS = $clog2(TIMEOUT)
- COL_BITS, $clog2(IMG_W), column index width (derived)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state
- band_valid  in  1  line buffer has a WIN-row band stable on the engine inputs
- band_ready  out  1  scheduler can accept a band
- row_done  out  1  one-cycle pulse; band fully processed, upstream may change band data
- eng_rst  out  1  active-high reset to the engine
- eng_start  out  1  one-cycle input_ready pulse to the engine
- eng_col  out  COL_BITS  col_index to the engine
- eng_done  in  1  engine done
- eng_disp  in  DISP_BITS  engine output_disp
- disp_valid  out  1  disparity word valid
- disp_ready  in  1  downstream accepts
- disp_data  out  DISP_BITS  disparity
- disp_col  out  COL_BITS  column of disp_data
- disp_last  out  1  final column of the band
- timeout_err  out  1  sticky; set on any timeout; cleared only by rst

Behaviour:
- Reset values (rst low, immediate): state=IDLE, col=0, timer=0. Outputs: band_ready=0, row_done=0, eng_rst=1, eng_start=0, eng_col=0, disp_valid=0, disp_data=0, disp_col=0, disp_last=0, timeout_err=0.
- Engine hold: eng_rst is asserted in IDLE and CLR and deasserted in every other state.
- IDLE: band_ready=1. On band_valid&&band_ready: col<=0, go to CLR.
- CLR (1 cycle): eng_rst=1, then go to GO.
- GO (1 cycle): eng_start=1, eng_col=col, timer<=0, then go to WAIT. eng_col holds col in WAIT and EMIT.
- WAIT, eng_done=1: disp_data<=eng_disp, go to EMIT.
- WAIT, timer==TIMEOUT-1 without eng_done: disp_data<=0, timeout_err<=1, go to EMIT.
- WAIT, otherwise: timer++.
- WAIT, simultaneous done and timeout: done wins, no error.
- EMIT: disp_valid=1, disp_col=col, disp_last=(col==IMG_W-WIN). disp_data, disp_col and disp_last are held stable until disp_ready. disp_valid is never dropped without a handshake.
- EMIT handshake (disp_valid&&disp_ready):
  - Last column: row_done pulses that cycle, go to IDLE.
  - Otherwise: col++, go to CLR.
- Per-column overhead: 3 cycles plus engine latency plus downstream stall. Minimum 4 cycles per column when done arrives in the first WAIT cycle and disp_ready is high.
- Columns per band: IMG_W-WIN+1 (50 at defaults), emitted strictly in ascending order, no gaps.
- band_valid is ignored outside IDLE. Upstream must hold band data until row_done.
- Back-to-back bands: band_ready rises the cycle after row_done. The next band is accepted on the following edge.
- eng_done outside WAIT is ignored.
- Reset mid-band: everything returns to reset values. The partial row is discarded, no row_done, no further disp_valid.
- Counter widths: col never exceeds IMG_W-WIN. timer saturates at TIMEOUT-1 and never wraps.

Test Plan:
- Single band, engine model returning disp=col%64 with 5-cycle latency, disp_ready=1 -> 50 words; disp_col 0..49, disp_data==col, disp_last only on col 49, one row_done, timeout_err=0, band_ready low throughout.
- Downstream stall: disp_ready low for 7 cycles at col 10 -> disp_valid and disp_data held constant, no eng_start issued, col 11 starts only after the handshake.
- Timeout: engine never asserts done at col 3, TIMEOUT=16 -> word with disp_col=3, disp_data=0, emitted 16 cycles after the start pulse; timeout_err=1 and stays 1; cols 4..49 continue normally.
- Race: eng_done asserted in exactly the cycle timer==TIMEOUT-1 -> engine value emitted, timeout_err stays 0.
- Mid-band reset: rst low during col 20 WAIT -> all outputs at reset values immediately, eng_rst=1. After release, a new band restarts at col 0.
- Two bands back-to-back with band_valid held high -> 100 words total; second band accepted the cycle after band_ready rises; exactly two row_done pulses.

Source files
------------

// File: rtl/disp_row_scheduler_if.sv
// Band, engine and disparity-stream signals between the row scheduler and its neighbours.
// master = scheduler side, slave = line buffer / engine / depth-map writer side.
interface disp_row_scheduler_if #(
  parameter int COL_BITS  = 6,
  parameter int DISP_BITS = 6
);
  logic                 band_valid;
  logic                 band_ready;
  logic                 row_done;
  logic                 eng_rst;
  logic                 eng_start;
  logic [COL_BITS-1:0]  eng_col;
  logic                 eng_done;
  logic [DISP_BITS-1:0] eng_disp;
  logic                 disp_valid;
  logic                 disp_ready;
  logic [DISP_BITS-1:0] disp_data;
  logic [COL_BITS-1:0]  disp_col;
  logic                 disp_last;
  logic                 timeout_err;

  modport master (
    input  band_valid, eng_done, eng_disp, disp_ready,
    output band_ready, row_done, eng_rst, eng_start, eng_col,
           disp_valid, disp_data, disp_col, disp_last, timeout_err
  );

  modport slave (
    output band_valid, eng_done, eng_disp, disp_ready,
    input  band_ready, row_done, eng_rst, eng_start, eng_col,
           disp_valid, disp_data, disp_col, disp_last, timeout_err
  );
endinterface

// File: rtl/disp_row_scheduler.sv
// Runs one disparity engine across every window column of a band; >=4 cycles/column (clear, start, wait, emit).
// Backpressure: the emitted word is held until disp_ready; no new engine start until it is taken.
module disp_row_scheduler #(
  parameter int WIN       = 15,
  parameter int IMG_W     = 64,
  parameter int MAX_DISP  = 64,
  parameter int TIMEOUT   = 4096,
  localparam int DISP_BITS = $clog2(MAX_DISP),
  localparam int TMR_BITS  = $clog2(TIMEOUT),
  localparam int COL_BITS  = $clog2(IMG_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  disp_row_scheduler_if.master bus
);

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_W - WIN);
  localparam logic [TMR_BITS-1:0] TMR_MAX  = TMR_BITS'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_GO, S_WAIT, S_EMIT} state_t;

  state_t               state_q, state_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic [TMR_BITS-1:0]  timer_q, timer_d;
  logic [DISP_BITS-1:0] disp_data_q, disp_data_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 band_ready_q, band_ready_d;
  logic                 is_last;
  logic                 emit_fire;

  assign is_last   = (col_q == LAST_COL);
  assign emit_fire = (state_q == S_EMIT) && bus.disp_ready;

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    timer_d       = timer_q;
    disp_data_d   = disp_data_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.band_valid && band_ready_q) begin
          col_d   = '0;
          state_d = S_CLR;
        end
      end
      S_CLR: state_d = S_GO;
      S_GO: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a timeout landing on the same cycle
        if (bus.eng_done) begin
          disp_data_d = bus.eng_disp;
          state_d     = S_EMIT;
        end else if (timer_q == TMR_MAX) begin
          disp_data_d   = '0;
          timeout_err_d = 1'b1;
          state_d       = S_EMIT;
        end else begin
          timer_d = timer_q + TMR_BITS'(1);
        end
      end
      S_EMIT: begin
        if (bus.disp_ready) begin
          if (is_last) begin
            state_d = S_IDLE;
          end else begin
            col_d   = col_q + COL_BITS'(1);
            state_d = S_CLR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // registered so band_ready stays low while in reset and rises one cycle after row_done
    band_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      col_q         <= '0;
      timer_q       <= '0;
      disp_data_q   <= '0;
      timeout_err_q <= 1'b0;
      band_ready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      timer_q       <= timer_d;
      disp_data_q   <= disp_data_d;
      timeout_err_q <= timeout_err_d;
      band_ready_q  <= band_ready_d;
    end
  end

  assign bus.band_ready  = band_ready_q;
  assign bus.row_done    = emit_fire && is_last;
  assign bus.eng_rst     = (state_q == S_IDLE) || (state_q == S_CLR);
  assign bus.eng_start   = (state_q == S_GO);
  assign bus.eng_col     = col_q;
  assign bus.disp_valid  = (state_q == S_EMIT);
  assign bus.disp_data   = disp_data_q;
  assign bus.disp_col    = col_q;
  assign bus.disp_last   = (state_q == S_EMIT) && is_last;
  assign bus.timeout_err = timeout_err_q;

endmodule
